// File: rtl/flags_pkg.sv
// Shared definitions for the condition-flag producer and the branch condition tester.
package flags_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'b00,
    CLS_ADD   = 2'b01,
    CLS_SUB   = 2'b10,
    CLS_LOGIC = 2'b11
  } alu_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } flags_state_e;

endpackage

// File: rtl/flags_register_if.sv
// ALU result bus feeding the flags register; the ALU drives it, the flags register consumes it.
interface flags_register_if #(
  parameter int WIDTH = 32
);
  import flags_pkg::*;

  logic             alu_valid;
  alu_class_e       alu_class;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             op_a_msb;
  logic             op_b_msb;

  modport master (
    output alu_valid, alu_class, alu_result, alu_carry, op_a_msb, op_b_msb
  );

  modport slave (
    input alu_valid, alu_class, alu_result, alu_carry, op_a_msb, op_b_msb
  );

endinterface

// File: rtl/flags_register_flag_gen.sv
// Combinational Z/C/S/O derivation from one ALU result; class none yields all zeros.
module flag_gen
  import flags_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_class_e       i_class,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_carry,
  input  logic             i_a_msb,
  input  logic             i_b_msb,
  output logic [3:0]       o_flags
);

  logic w_sign;

  assign w_sign = i_result[WIDTH-1];

  always_comb begin
    o_flags = '0;
    if (i_class != CLS_NONE) begin
      o_flags[FLAG_Z] = (i_result == '0);
      o_flags[FLAG_S] = w_sign;
    end
    // Signed overflow: operand signs agree (add) or differ (sub), result sign differs from A.
    case (i_class)
      CLS_ADD: begin
        o_flags[FLAG_C] = i_carry;
        o_flags[FLAG_O] = (i_a_msb == i_b_msb) && (w_sign != i_a_msb);
      end
      CLS_SUB: begin
        o_flags[FLAG_C] = i_carry;
        o_flags[FLAG_O] = (i_a_msb != i_b_msb) && (w_sign != i_a_msb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/flags_register.sv
// Condition-flag register: pending/commit pipeline, bypass view, single-level shadow copy.
//   state | meaning
//   IDLE  | no uncommitted flag update; flags_fwd shows committed flags
//   PEND  | pend_data holds an update that commits at the next edge unless flushed
module flags_register
  import flags_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  flags_register_if.slave alu_if,
  input  logic       i_flush,
  input  logic       i_flags_wr,
  input  logic [3:0] i_flags_wr_data,
  input  logic       i_save,
  input  logic       i_restore,
  output logic [3:0] o_flags,
  output logic [3:0] o_flags_fwd,
  output logic       o_pending
);

  flags_state_e r_state;
  logic [3:0]   r_flags;
  logic [3:0]   r_shadow;
  logic [3:0]   r_pend_data;

  logic [3:0]   w_gen_flags;
  logic         w_qual;
  logic         w_commit;
  logic [3:0]   w_flags_nxt;

  flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .i_class  (alu_if.alu_class),
    .i_result (alu_if.alu_result),
    .i_carry  (alu_if.alu_carry),
    .i_a_msb  (alu_if.op_a_msb),
    .i_b_msb  (alu_if.op_b_msb),
    .o_flags  (w_gen_flags)
  );

  assign w_qual   = alu_if.alu_valid && (alu_if.alu_class != CLS_NONE);
  assign w_commit = (r_state == ST_PEND) && !i_flush;

  // Losing write sources are dropped, never deferred.
  always_comb begin
    w_flags_nxt = r_flags;
    if (i_restore)       w_flags_nxt = r_shadow;
    else if (i_flags_wr) w_flags_nxt = i_flags_wr_data;
    else if (w_commit)   w_flags_nxt = r_pend_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_flags     <= '0;
      r_shadow    <= '0;
      r_pend_data <= '0;
    end else begin
      r_flags <= w_flags_nxt;
      // With save and restore together this rewrites the old shadow value.
      if (i_save) r_shadow <= w_flags_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_qual) begin
            r_pend_data <= w_gen_flags;
            r_state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else if (w_qual) begin
            r_pend_data <= w_gen_flags;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_flags     = r_flags;
  assign o_pending   = (r_state == ST_PEND);
  assign o_flags_fwd = o_pending ? r_pend_data : r_flags;

endmodule

// File: tb/tb_flags_register.sv
// Directed self-checking bench for flags_register with hand-computed flag values.
module tb_flags_register;
  import flags_pkg::*;

  localparam int WIDTH = 32;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       flags_wr;
  logic [3:0] flags_wr_data;
  logic       save;
  logic       restore;
  logic [3:0] flags;
  logic [3:0] flags_fwd;
  logic       pending;

  int n_cmp;
  int n_err;

  flags_register_if #(.WIDTH(WIDTH)) alu_if ();

  flags_register #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_if          (alu_if.slave),
    .i_flush         (flush),
    .i_flags_wr      (flags_wr),
    .i_flags_wr_data (flags_wr_data),
    .i_save          (save),
    .i_restore       (restore),
    .o_flags         (flags),
    .o_flags_fwd     (flags_fwd),
    .o_pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    alu_if.alu_valid  = 1'b0;
    alu_if.alu_class  = CLS_NONE;
    alu_if.alu_result = '0;
    alu_if.alu_carry  = 1'b0;
    alu_if.op_a_msb   = 1'b0;
    alu_if.op_b_msb   = 1'b0;
    flush         = 1'b0;
    flags_wr      = 1'b0;
    flags_wr_data = 4'b0000;
    save          = 1'b0;
    restore       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input alu_class_e cls, input logic [WIDTH-1:0] res,
                        input logic carry, input logic a_msb, input logic b_msb);
    alu_if.alu_valid  = 1'b1;
    alu_if.alu_class  = cls;
    alu_if.alu_result = res;
    alu_if.alu_carry  = carry;
    alu_if.op_a_msb   = a_msb;
    alu_if.op_b_msb   = b_msb;
  endtask

  task automatic load_flags(input logic [3:0] v);
    clear_inputs();
    flags_wr = 1'b1; flags_wr_data = v;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    n_cmp++; if (flags_fwd !== 4'b0000) begin n_err++; $display("FAIL reset_fwd got=%b exp=0000", flags_fwd); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%b exp=0", pending); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_latency();
    alu_op(CLS_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    n_cmp++; if (flags_fwd !== 4'b1100) begin n_err++; $display("FAIL add_fwd got=%b exp=1100", flags_fwd); end
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL add_pending got=%b exp=1", pending); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL add_flags_early got=%b exp=0000", flags); end
    step();
    n_cmp++; if (flags !== 4'b1100) begin n_err++; $display("FAIL add_commit got=%b exp=1100", flags); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL add_pending_clr got=%b exp=0", pending); end
  endtask

  task automatic test_sub_logic();
    alu_op(CLS_SUB, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step(); clear_inputs(); step();
    n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL sub_zero got=%b exp=0001", flags); end
    load_flags(4'b0010);
    n_cmp++; if (flags !== 4'b0010) begin n_err++; $display("FAIL wr_carry got=%b exp=0010", flags); end
    alu_op(CLS_LOGIC, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0);
    step(); clear_inputs(); step();
    n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL logic_flags got=%b exp=0100", flags); end
    alu_op(CLS_SUB, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    step(); clear_inputs(); step();
    n_cmp++; if (flags !== 4'b1110) begin n_err++; $display("FAIL sub_overflow got=%b exp=1110", flags); end
    alu_op(CLS_NONE, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    step(); clear_inputs();
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL class_none_pending got=%b exp=0", pending); end
    step();
    n_cmp++; if (flags !== 4'b1110) begin n_err++; $display("FAIL class_none_flags got=%b exp=1110", flags); end
  endtask

  task automatic test_back_to_back();
    alu_op(CLS_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    step();
    alu_op(CLS_ADD, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    n_cmp++; if (flags !== 4'b0011) begin n_err++; $display("FAIL b2b_first got=%b exp=0011", flags); end
    n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL b2b_pending got=%b exp=1", pending); end
    n_cmp++; if (flags_fwd !== 4'b0000) begin n_err++; $display("FAIL b2b_fwd got=%b exp=0000", flags_fwd); end
    step();
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL b2b_second got=%b exp=0000", flags); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL b2b_pending_clr got=%b exp=0", pending); end
  endtask

  task automatic test_flush();
    load_flags(4'b0100);
    alu_op(CLS_ADD, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    flush = 1'b1;
    alu_op(CLS_ADD, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    step();
    clear_inputs();
    n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL flush_flags got=%b exp=0100", flags); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL flush_pending got=%b exp=0", pending); end
    n_cmp++; if (flags_fwd !== 4'b0100) begin n_err++; $display("FAIL flush_fwd got=%b exp=0100", flags_fwd); end
    step();
    n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL flush_no_commit got=%b exp=0100", flags); end
  endtask

  task automatic test_priority();
    alu_op(CLS_ADD, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    flags_wr = 1'b1; flags_wr_data = 4'b1000;
    n_cmp++; if (flags_fwd !== 4'b0001) begin n_err++; $display("FAIL wr_fwd_same_cycle got=%b exp=0001", flags_fwd); end
    step();
    clear_inputs();
    n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL wr_beats_commit got=%b exp=1000", flags); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL wr_consumes_pend got=%b exp=0", pending); end
    step();
    n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL wr_no_defer got=%b exp=1000", flags); end
  endtask

  task automatic test_save_restore();
    load_flags(4'b1010);
    save = 1'b1;
    step();
    clear_inputs();
    load_flags(4'b0001);
    n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL sr_overwrite got=%b exp=0001", flags); end
    alu_op(CLS_LOGIC, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    restore = 1'b1;
    n_cmp++; if (flags_fwd !== 4'b0100) begin n_err++; $display("FAIL sr_fwd_pend got=%b exp=0100", flags_fwd); end
    step();
    clear_inputs();
    n_cmp++; if (flags !== 4'b1010) begin n_err++; $display("FAIL restore_wins got=%b exp=1010", flags); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL restore_pending got=%b exp=0", pending); end
    flags_wr = 1'b1; flags_wr_data = 4'b0110; save = 1'b1;
    step();
    clear_inputs();
    load_flags(4'b0000);
    save = 1'b1; restore = 1'b1;
    step();
    clear_inputs();
    n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL save_post_priority got=%b exp=0110", flags); end
    load_flags(4'b1111);
    restore = 1'b1;
    step();
    clear_inputs();
    n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL save_restore_keep got=%b exp=0110", flags); end
  endtask

  task automatic test_reset_mid_pend();
    alu_op(CLS_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    n_cmp++; if (flags_fwd !== 4'b1100) begin n_err++; $display("FAIL mid_pend_setup got=%b exp=1100", flags_fwd); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL async_rst_flags got=%b exp=0000", flags); end
    n_cmp++; if (flags_fwd !== 4'b0000) begin n_err++; $display("FAIL async_rst_fwd got=%b exp=0000", flags_fwd); end
    n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL async_rst_pending got=%b exp=0", pending); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_no_commit got=%b exp=0000", flags); end
    load_flags(4'b1111);
    restore = 1'b1;
    step();
    clear_inputs();
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_shadow got=%b exp=0000", flags); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_add_latency();
    test_sub_logic();
    test_back_to_back();
    test_flush();
    test_priority();
    test_save_restore();
    test_reset_mid_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
